serial_tx_framer: RTL and testbench
===================================

SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1: the number of clk cycles each serial bit is held (legal range >= 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, 8 bits: the byte to transmit.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is offered for transfer.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-007 The block SHALL have port serial_out, output, 1 bit: the serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-009 The block SHALL have port sent, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-010 The block SHALL accept a byte on any rising edge where in_valid=1 and in_ready=1; there is no other transfer condition.
REQ-011 The block SHALL implement FSM states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be reachable only per REQ-026.
REQ-012 The block SHALL drive serial_out as a function of state: IDLE 1, START 0, DATA the current data bit LSB first, PARITY the parity bit, STOP 1.
REQ-013 The block SHALL hold each non-IDLE state for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter; DATA SHALL span 8 bit periods, tracked by a 3-bit index.
REQ-014 The block SHALL, in IDLE, load an accepted byte directly into the shift register and enter START on the accept edge, so serial_out=0 in the next cycle.
REQ-015 The block SHALL include a one-entry holding buffer; while busy=1, an accepted byte SHALL be written to the buffer.
REQ-016 The block SHALL drive in_ready = NOT buffer_full, so in_ready=1 in IDLE and while the buffer is empty.
REQ-017 The block SHALL, at the end of the last STOP cycle, move a full buffer into the shift register and enter START with no idle gap between frames.
REQ-018 The block SHALL, at the end of the last STOP cycle with the buffer empty and in_valid=1, accept in_data directly and enter START.
REQ-019 The block SHALL, at the end of the last STOP cycle with the buffer empty and in_valid=0, return to IDLE.
REQ-020 The block SHALL assert sent=1 during exactly the final cycle of STOP, once per frame.
REQ-021 The block SHALL drive busy=1 in every state other than IDLE.
REQ-022 The block SHALL give a frame length of 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity compiled in.
REQ-023 The block SHALL keep accepting bytes under sustained in_valid=1 without loss or duplication, in_ready=0 being the only stall mechanism.

Reset
REQ-024 The block SHALL, on a cycle with reset=1: set state IDLE, serial_out=1, busy=0, sent=0, in_ready=1, buffer empty, counters zero, and ignore in_valid.
REQ-025 The block SHALL, on reset mid-frame, abort the frame immediately with serial_out=1 next cycle, discard the buffered byte, and emit no sent pulse.

Configuration
REQ-026 The block SHALL, with macro SERIAL_TX_PARITY_EN defined, insert the PARITY state after DATA, transmitting even parity (XOR of the 8 data bits); without the macro, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Verification
REQ-027 The bench SHALL cover reset then idle 5 cycles -> serial_out=1, in_ready=1, busy=0, sent=0 throughout.
REQ-028 The bench SHALL cover CLKS_PER_BIT=1, no parity, send 0xA5 -> serial_out 0,1,0,1,0,0,1,0,1,1 on consecutive cycles, with sent=1 on the 10th.
REQ-029 The bench SHALL cover CLKS_PER_BIT=1, 0x00 then 0xFF offered back-to-back -> 20 contiguous bits 0,0x8,1,0,1x8,1, in_ready=0 while the buffer holds 0xFF, and two sent pulses 10 cycles apart.
REQ-030 The bench SHALL cover SERIAL_TX_PARITY_EN, send 0x07 -> serial_out 0,1,1,1,0,0,0,0,0,1,1 (parity=1), with sent on the 11th cycle.
REQ-031 The bench SHALL cover reset asserted during data bit 3 with a byte buffered -> serial_out=1 next cycle, no sent pulse, and the next accepted byte 0x3C transmits correctly.
REQ-032 The bench SHALL cover CLKS_PER_BIT=4, send 0x01 -> each bit held 4 cycles, 40-cycle frame, busy high exactly 40 cycles.

Source files
------------

// File: rtl/serial_tx_framer.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Latency: serial_out goes low the cycle after a byte is accepted; a frame lasts 10 (11 with parity) bit periods.
// Backpressure: a one-byte holding buffer; in_ready drops only while that buffer is occupied.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx_framer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       sent
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    buf_dat;
   logic          buf_full;
`ifdef SERIAL_TX_PARITY_EN
   logic          par_bit;
`endif

   logic       last_bit;
   logic       stop_end;
   logic       accept;
   logic       load_buf;
   logic       load_direct;
   logic       load;
   logic       buf_wr;
   logic [7:0] load_byte;

   assign last_bit    = (cnt == CW'(CLKS_PER_BIT - 1));
   assign stop_end    = (state == STOP) && last_bit;
   assign in_ready    = ~buf_full;
   assign accept      = in_valid & in_ready;
   assign busy        = (state != IDLE);
   assign sent        = stop_end & ~reset;
   // A new frame starts from the buffer first; otherwise the input is taken straight into the shifter.
   assign load_buf    = stop_end & buf_full;
   assign load_direct = accept & ((state == IDLE) | stop_end);
   assign load        = load_buf | load_direct;
   assign load_byte   = load_buf ? buf_dat : in_data;
   // Mid-frame accepts park in the buffer; the STOP-end accept goes directly to the shifter.
   assign buf_wr      = accept & busy & ~stop_end;

   // Line level is a pure function of the current state.
   always_comb begin
      serial_out = 1'b1;
      case (state)
         START:   serial_out = 1'b0;
         DATA:    serial_out = shift[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  serial_out = par_bit;
`endif
         default: serial_out = 1'b1;
      endcase
   end

   // Frame sequencing: bit-period counter, data-bit index and state transitions.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               idx <= '0;
               if (load) state <= START;
            end
            START: begin
               if (last_bit) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (last_bit) begin
                  cnt <= '0;
                  idx <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (last_bit) begin
                  cnt   <= '0;
                  state <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif
            STOP: begin
               if (last_bit) begin
                  cnt   <= '0;
                  state <= load ? START : IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Shift register: loaded at frame start, shifted at the end of each data bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift <= '0;
      end else if (load) begin
         shift <= load_byte;
      end else if ((state == DATA) && last_bit) begin
         shift <= {1'b0, shift[7:1]};
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   // Even parity of the byte, captured when it enters the shifter.
   always_ff @(posedge clk) begin
      if (reset)     par_bit <= 1'b0;
      else if (load) par_bit <= ^load_byte;
   end
`endif

   // One-entry holding buffer filled mid-frame and drained at frame end.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full <= 1'b0;
         buf_dat  <= '0;
      end else if (buf_wr) begin
         buf_full <= 1'b1;
         buf_dat  <= in_data;
      end else if (load_buf) begin
         buf_full <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: two instances (1 and 4 clocks per bit), scoreboard of per-cycle line expectations.
// Expectations {serial_out, busy, sent} are queued when a byte is accepted and popped every falling edge.
// Define SERIAL_TX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_serial_tx_framer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d1, d4;
   logic       v1, v4;
   logic       rdy1, rdy4, so1, so4, busy1, busy4, sent1, sent4;

   int nvec = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   logic [2:0] q1[$];
   logic [2:0] q4[$];

   always #5 clk = ~clk;

   serial_tx_framer #(.CLKS_PER_BIT(1)) u1 (
      .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
      .serial_out(so1), .busy(busy1), .sent(sent1));

   serial_tx_framer #(.CLKS_PER_BIT(4)) u4 (
      .clk(clk), .reset(reset), .in_data(d4), .in_valid(v4), .in_ready(rdy4),
      .serial_out(so4), .busy(busy4), .sent(sent4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Queue every cycle of one frame: start, data LSB first, optional parity, stop (sent on its last cycle).
   task automatic push_frame(input logic [7:0] b, input bit wide);
      logic bits[$];
      int cpb;
      cpb = wide ? 4 : 1;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef SERIAL_TX_PARITY_EN
      bits.push_back(^b);
`endif
      bits.push_back(1'b1);
      for (int i = 0; i < bits.size(); i++)
         for (int c = 0; c < cpb; c++) begin
            logic [2:0] e;
            e = {bits[i], 1'b1, (i == bits.size() - 1) && (c == cpb - 1)};
            if (wide) q4.push_back(e);
            else      q1.push_back(e);
         end
   endtask

   // Per-cycle line checks; an empty queue means the line must be idle.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [2:0] e;
         e = (q1.size() > 0) ? q1.pop_front() : 3'b100;
         chk("u1_line", {29'd0, so1, busy1, sent1}, {29'd0, e});
         e = (q4.size() > 0) ? q4.pop_front() : 3'b100;
         chk("u4_line", {29'd0, so4, busy4, sent4}, {29'd0, e});
      end
   end

   // Offer a byte until accepted; inputs change 1 time unit after the falling edge.
   task automatic send(input logic [7:0] b, input bit wide);
      bit done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         if (wide) begin v4 = 1'b1; d4 = b; end
         else      begin v1 = 1'b1; d1 = b; end
         if ((wide ? rdy4 : rdy1) === 1'b1) begin
            push_frame(b, wide);
            done = 1'b1;
         end
         @(negedge clk); #1;
         if (wide) v4 = 1'b0;
         else      v1 = 1'b0;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && (q1.size() > 0 || q4.size() > 0); t++) @(negedge clk);
      if (q1.size() > 0 || q4.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
      @(negedge clk); #1;
   endtask

   initial begin
      int busy_cnt;
      reset = 1'b1; v1 = 1'b0; v4 = 1'b0; d1 = '0; d4 = '0;
      @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;

      // Idle after reset: monitor checks the line, here the handshake side.
      for (int i = 0; i < 5; i++) begin
         chk("idle_rdy1", {31'd0, rdy1}, 32'd1);
         chk("idle_rdy4", {31'd0, rdy4}, 32'd1);
         @(negedge clk); #1;
      end

      // Single frame 0xA5.
      send(8'hA5, 1'b0);
      drain();

      // Back-to-back 0x00, 0xFF: second byte parks in the buffer.
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      for (int i = 0; i < 7; i++) begin
         chk("buf_full_rdy", {31'd0, rdy1}, 32'd0);
         @(negedge clk); #1;
      end
      drain();
      chk("rdy_after_b2b", {31'd0, rdy1}, 32'd1);

      // 0x07: parity bit is 1 when the parity build is enabled.
      send(8'h07, 1'b0);
      drain();

      // Reset during data bit 3 with a byte buffered; both frames are dropped.
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      q1.delete();
      q4.delete();
      @(negedge clk); #1;
      reset = 1'b0;
      chk("rst_rdy", {31'd0, rdy1}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      send(8'h3C, 1'b0);
      drain();

      // Four clocks per bit: 0x01, and count the busy window.
      busy_cnt = 0;
      send(8'h01, 1'b1);
      for (int i = 0; i < 60; i++) begin
         if (busy4 === 1'b1) busy_cnt++;
         @(negedge clk);
      end
`ifdef SERIAL_TX_PARITY_EN
      chk("busy4_len", busy_cnt, 32'd44);
`else
      chk("busy4_len", busy_cnt, 32'd40);
`endif
      drain();

      // Sustained offers on the wide instance: three bytes, no loss or duplication.
      send(8'h5A, 1'b1);
      send(8'hC3, 1'b1);
      send(8'h81, 1'b1);
      drain();

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
